// File: rtl/axis_pkg.sv
// Shared stream-FIFO helpers: pointer/level width and reset values of the
// registered handshake flags.
package axis_pkg;

  // Pointers and counters carry one extra bit so full and empty stay distinct.
  function automatic int ptr_w(input int abits);
    return abits + 1;
  endfunction

  localparam logic RST_S_TREADY = 1'b0;
  localparam logic RST_M_TVALID = 1'b0;

endpackage

// File: rtl/lutram_sdp.sv
// Simple dual-port LUT SRAM: synchronous write, asynchronous read.
module lutram_sdp #(
  parameter int AW = 4,
  parameter int DW = 9
) (
  input  logic          aclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge aclk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sfifo.sv
// Single-clock AXI4-Stream FIFO on LUT SRAM with fill level and packet count.
// Define AXIS_SFIFO_PACKET_EN for store-and-forward output gating.
module axis_sfifo
  import axis_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TLAST = 1,
  parameter int ABITS = 4
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [WIDTH-1:0] s_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata,
  output logic [ABITS:0]   level_o,
  output logic [ABITS:0]   packets_o
);

  localparam int DW = WIDTH + TLAST;

  typedef logic [ptr_w(ABITS)-1:0] ptr_t;
  typedef logic [ptr_w(ABITS)-1:0] level_t;

`ifdef AXIS_SFIFO_PACKET_EN
  if (TLAST == 0) begin : g_cfg_err
    $error("axis_sfifo: packet mode needs TLAST=1");
  end
`endif

  ptr_t            wptr, rptr, wptr_nx, rptr_nx;
  level_t          level_nx, pkts_nx;
  logic            push, pop, push_last, pop_last;
  logic            full_nx, empty_nx, vld_nx;
  logic [DW-1:0]   wdata, rdata;

  assign push = s_tvalid & s_tready;
  assign pop  = m_tvalid & m_tready;

  if (TLAST != 0) begin : g_last
    assign wdata     = {s_tlast, s_tdata};
    assign m_tdata   = rdata[WIDTH-1:0];
    // RAM contents are unreset; only expose tlast alongside a valid beat.
    assign m_tlast   = rdata[DW-1] & m_tvalid;
    assign push_last = push & s_tlast;
    assign pop_last  = pop & m_tlast;
  end else begin : g_nolast
    assign wdata     = s_tdata;
    assign m_tdata   = rdata;
    assign m_tlast   = 1'b0;
    assign push_last = 1'b0;
    assign pop_last  = 1'b0;
  end

  lutram_sdp #(.AW(ABITS), .DW(DW)) u_ram (
    .aclk  (aclk),
    .we    (push),
    .waddr (wptr[ABITS-1:0]),
    .wdata (wdata),
    .raddr (rptr[ABITS-1:0]),
    .rdata (rdata)
  );

  // Flags are computed from next-state pointers so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    wptr_nx  = wptr + ptr_t'(push);
    rptr_nx  = rptr + ptr_t'(pop);
    level_nx = level_o;
    pkts_nx  = packets_o;
    case ({push, pop})
      2'b10:   level_nx = level_o + level_t'(1);
      2'b01:   level_nx = level_o - level_t'(1);
      default: level_nx = level_o;
    endcase
    case ({push_last, pop_last})
      2'b10:   pkts_nx = packets_o + level_t'(1);
      2'b01:   pkts_nx = packets_o - level_t'(1);
      default: pkts_nx = packets_o;
    endcase
    empty_nx = (wptr_nx == rptr_nx);
    full_nx  = (wptr_nx[ABITS-1:0] == rptr_nx[ABITS-1:0]) &&
               (wptr_nx[ABITS] != rptr_nx[ABITS]);
`ifdef AXIS_SFIFO_PACKET_EN
    // Full releases an oversize packet cut-through so the FIFO cannot deadlock.
    vld_nx   = (pkts_nx != '0) | full_nx;
`else
    vld_nx   = ~empty_nx;
`endif
  end

  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      wptr      <= '0;
      rptr      <= '0;
      level_o   <= '0;
      packets_o <= '0;
      s_tready  <= RST_S_TREADY;
      m_tvalid  <= RST_M_TVALID;
    end else begin
      wptr      <= wptr_nx;
      rptr      <= rptr_nx;
      level_o   <= level_nx;
      packets_o <= pkts_nx;
      s_tready  <= ~full_nx;
      m_tvalid  <= vld_nx;
    end

endmodule
